// File: rtl/entry_controller_if.sv
// Keypad, calculator and display signals of the entry controller, bundled so the
// controller (slave) and its environment (master) share one port list.
interface entry_controller_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [1:0]  key_flags;
    logic        clear;
    logic        calc_ready;
    logic        calc_error;
    logic [15:0] calc_result;
    logic        calc_start;
    logic        calc_abort;
    logic [15:0] calc_operand;
    logic [31:0] disp_numb;
    logic [7:0]  disp_mask;
    logic        disp_error;
    logic        busy;

    modport master (
        output key_valid, key_code, key_flags, clear,
        output calc_ready, calc_error, calc_result,
        input  calc_start, calc_abort, calc_operand,
        input  disp_numb, disp_mask, disp_error, busy
    );

    modport slave (
        input  key_valid, key_code, key_flags, clear,
        input  calc_ready, calc_error, calc_result,
        output calc_start, calc_abort, calc_operand,
        output disp_numb, disp_mask, disp_error, busy
    );
endinterface

// File: rtl/entry_controller.sv
// Hex keypad entry controller: collects up to eight digits for display, hands the
// low 16 bits to a calculator on Enter and shows its result, error or timeout.
module entry_controller #(
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    entry_controller_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_WAIT_CALC,
        S_SHOW_RES,
        S_SHOW_ERR
    } state_t;

    localparam logic [19:0] TIMER_LAST = 20'(TIMEOUT - 1);

    state_t      r_state, w_state_nx;
    logic [3:0]  r_count, w_count_nx;
    logic [19:0] r_timer, w_timer_nx;
    logic [31:0] r_disp_numb, w_disp_numb_nx;
    logic [7:0]  r_disp_mask, w_disp_mask_nx;
    logic        r_disp_error, w_disp_error_nx;
    logic [15:0] r_calc_operand, w_calc_operand_nx;
    logic        r_calc_start, w_calc_start_nx;
    logic        r_calc_abort, w_calc_abort_nx;
    logic        r_busy;

    logic        w_enter, w_digit, w_timeout;
    logic [3:0]  w_count_inc;

    // Enter wins whenever its flag is set, even if the digit flag is set too.
    assign w_enter     = bus.key_valid & bus.key_flags[1];
    assign w_digit     = bus.key_valid & (bus.key_flags == 2'b01);
    assign w_timeout   = (r_timer == TIMER_LAST);
    assign w_count_inc = (r_count >= 4'd8) ? 4'd8 : r_count + 4'd1;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path infers a latch.
        w_state_nx        = r_state;
        w_count_nx        = r_count;
        w_timer_nx        = r_timer;
        w_disp_numb_nx    = r_disp_numb;
        w_disp_mask_nx    = r_disp_mask;
        w_disp_error_nx   = r_disp_error;
        w_calc_operand_nx = r_calc_operand;
        w_calc_start_nx   = 1'b0;
        w_calc_abort_nx   = 1'b0;

        if (bus.clear) begin
            w_state_nx      = S_IDLE;
            w_count_nx      = 4'd0;
            w_timer_nx      = 20'd0;
            w_disp_numb_nx  = 32'h0;
            w_disp_mask_nx  = 8'hFF;
            w_disp_error_nx = 1'b0;
            w_calc_abort_nx = (r_state == S_WAIT_CALC);
        end else begin
            unique case (r_state)
                S_IDLE, S_ENTRY: begin
                    if (w_digit) begin
                        w_state_nx     = S_ENTRY;
                        w_count_nx     = w_count_inc;
                        w_disp_numb_nx = {r_disp_numb[27:0], bus.key_code};
                        w_disp_mask_nx = 8'hFF << w_count_inc;
                    end else if (w_enter && r_state == S_ENTRY) begin
                        w_state_nx        = S_WAIT_CALC;
                        w_timer_nx        = 20'd0;
                        w_calc_operand_nx = r_disp_numb[15:0];
                        w_calc_start_nx   = 1'b1;
                    end
                end
                S_WAIT_CALC: begin
                    // A result arriving on the timeout cycle is still accepted.
                    if (bus.calc_ready) begin
                        if (bus.calc_error) begin
                            w_state_nx      = S_SHOW_ERR;
                            w_disp_error_nx = 1'b1;
                            w_disp_mask_nx  = 8'hFF;
                        end else begin
                            w_state_nx      = S_SHOW_RES;
                            w_disp_numb_nx  = {16'h0000, bus.calc_result};
                            w_disp_mask_nx  = 8'hF0;
                            w_disp_error_nx = 1'b0;
                        end
                    end else if (w_timeout) begin
                        w_state_nx      = S_SHOW_ERR;
                        w_calc_abort_nx = 1'b1;
                        w_disp_error_nx = 1'b1;
                        w_disp_mask_nx  = 8'hFF;
                    end else begin
                        w_timer_nx = r_timer + 20'd1;
                    end
                end
                S_SHOW_RES, S_SHOW_ERR: begin
                    if (w_digit) begin
                        w_state_nx      = S_ENTRY;
                        w_count_nx      = 4'd1;
                        w_disp_numb_nx  = {28'h0, bus.key_code};
                        w_disp_mask_nx  = 8'hFE;
                        w_disp_error_nx = 1'b0;
                    end else if (w_enter && r_state == S_SHOW_RES) begin
                        w_state_nx        = S_WAIT_CALC;
                        w_timer_nx        = 20'd0;
                        w_calc_operand_nx = r_disp_numb[15:0];
                        w_calc_start_nx   = 1'b1;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_count        <= 4'd0;
            r_timer        <= 20'd0;
            r_disp_numb    <= 32'h0;
            r_disp_mask    <= 8'hFF;
            r_disp_error   <= 1'b0;
            r_calc_operand <= 16'h0;
            r_calc_start   <= 1'b0;
            r_calc_abort   <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_state        <= w_state_nx;
            r_count        <= w_count_nx;
            r_timer        <= w_timer_nx;
            r_disp_numb    <= w_disp_numb_nx;
            r_disp_mask    <= w_disp_mask_nx;
            r_disp_error   <= w_disp_error_nx;
            r_calc_operand <= w_calc_operand_nx;
            r_calc_start   <= w_calc_start_nx;
            r_calc_abort   <= w_calc_abort_nx;
            r_busy         <= (w_state_nx == S_WAIT_CALC);
        end
    end

    assign bus.calc_start   = r_calc_start;
    assign bus.calc_abort   = r_calc_abort;
    assign bus.calc_operand = r_calc_operand;
    assign bus.disp_numb    = r_disp_numb;
    assign bus.disp_mask    = r_disp_mask;
    assign bus.disp_error   = r_disp_error;
    assign bus.busy         = r_busy;
endmodule

// File: tb/tb_entry_controller.sv
// Scoreboard bench for entry_controller: a digit-queue reference model predicts pulses
// and display changes with their cycle stamps; a negedge monitor consumes them.
module tb_entry_controller;
    localparam int TIMEOUT = 16;
    localparam logic [41:0] RST_SNAP = {32'h0, 8'hFF, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    entry_controller_if bus ();
    entry_controller #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int stamp; logic is_abort; logic [15:0] operand; } pulse_t;
    typedef struct { int stamp; logic [41:0] snap; } snap_t;
    pulse_t pulse_q[$];
    snap_t  snap_q[$];

    // Reference model: the display is derived from the list of entered digits.
    string       m_mode;
    logic [3:0]  m_digits[$];
    logic [31:0] m_numb;
    logic [7:0]  m_mask;
    bit          m_err, m_busy;
    logic [15:0] m_operand;
    int          m_start;
    logic [41:0] m_last;

    function automatic void model_reset();
        m_mode = "idle";
        m_digits.delete();
        m_numb = 32'h0; m_mask = 8'hFF; m_err = 1'b0; m_busy = 1'b0;
        m_operand = 16'h0; m_start = 0; m_last = RST_SNAP;
        pulse_q.delete();
        snap_q.delete();
    endfunction

    function automatic void show_digits();
        m_numb = 32'h0;
        foreach (m_digits[i]) m_numb = m_numb * 16 + 32'(m_digits[i]);
        m_mask = 8'(256 - (1 << m_digits.size()));
    endfunction

    function automatic void model_step(bit kv, logic [3:0] code, logic [1:0] flags, bit clr,
                                       bit cr, bit cerr, logic [15:0] res, int stamp);
        bit enter, digit;
        logic [41:0] snap;
        enter = kv && flags[1];
        digit = kv && (flags == 2'b01);
        if (clr) begin
            if (m_mode == "wait") pulse_q.push_back(pulse_t'{stamp, 1'b1, m_operand});
            m_digits.delete();
            m_numb = 32'h0; m_mask = 8'hFF; m_err = 1'b0; m_busy = 1'b0; m_mode = "idle";
        end else if (m_mode == "wait") begin
            if (cr) begin
                m_busy = 1'b0;
                if (cerr) begin
                    m_err = 1'b1; m_mask = 8'hFF; m_mode = "err";
                end else begin
                    m_numb = {16'h0, res}; m_mask = 8'hF0; m_err = 1'b0; m_mode = "res";
                end
            end else if (stamp - m_start == TIMEOUT) begin
                pulse_q.push_back(pulse_t'{stamp, 1'b1, m_operand});
                m_err = 1'b1; m_mask = 8'hFF; m_busy = 1'b0; m_mode = "err";
            end
        end else if (digit) begin
            if (m_mode == "res" || m_mode == "err") m_digits.delete();
            m_digits.push_back(code);
            if (m_digits.size() > 8) void'(m_digits.pop_front());
            show_digits();
            m_err = 1'b0;
            m_mode = "entry";
        end else if (enter && (m_mode == "entry" || m_mode == "res")) begin
            m_operand = m_numb[15:0];
            pulse_q.push_back(pulse_t'{stamp, 1'b0, m_operand});
            m_start = stamp; m_busy = 1'b1; m_mode = "wait";
        end
        snap = {m_numb, m_mask, m_err, m_busy};
        if (snap !== m_last) begin
            snap_q.push_back(snap_t'{stamp, snap});
            m_last = snap;
        end
    endfunction

    // Monitor: consumes expectations whenever the DUT pulses or its display changes.
    bit          mon_en = 1'b0;
    logic [41:0] mon_last;
    pulse_t      mp;
    snap_t       ms;
    logic [41:0] cur;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.calc_start || bus.calc_abort) begin
                check("start_abort_exclusive", 64'(bus.calc_start & bus.calc_abort), 64'd0);
                if (pulse_q.size() == 0) begin
                    check("unexpected_pulse", 64'({bus.calc_start, bus.calc_abort}), 64'd0);
                end else begin
                    mp = pulse_q.pop_front();
                    check("pulse_is_abort", 64'(bus.calc_abort), 64'(mp.is_abort));
                    check("pulse_cycle", 64'(cyc), 64'(mp.stamp));
                    if (!mp.is_abort) check("calc_operand", 64'(bus.calc_operand), 64'(mp.operand));
                end
            end
            if (pulse_q.size() > 0 && pulse_q[0].stamp < cyc) begin
                mp = pulse_q.pop_front();
                check("pulse_missing_cycle", 64'(cyc), 64'(mp.stamp));
            end
            cur = {bus.disp_numb, bus.disp_mask, bus.disp_error, bus.busy};
            if (cur !== mon_last) begin
                if (snap_q.size() == 0) begin
                    check("unexpected_display_change", 64'(cur), 64'(mon_last));
                end else begin
                    ms = snap_q.pop_front();
                    check("display_snapshot", 64'(cur), 64'(ms.snap));
                    check("display_cycle", 64'(cyc), 64'(ms.stamp));
                end
                mon_last = cur;
            end
            if (snap_q.size() > 0 && snap_q[0].stamp < cyc) begin
                ms = snap_q.pop_front();
                check("display_missing_cycle", 64'(cyc), 64'(ms.stamp));
            end
        end
    end

    task automatic drive(input bit kv, input logic [3:0] code, input logic [1:0] flags, input bit clr,
                         input bit cr, input bit cerr, input logic [15:0] res);
        @(negedge clk);
        bus.key_valid   = kv;
        bus.key_code    = code;
        bus.key_flags   = flags;
        bus.clear       = clr;
        bus.calc_ready  = cr;
        bus.calc_error  = cerr;
        bus.calc_result = res;
        model_step(kv, code, flags, clr, cr, cerr, res, cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic key_digit(input logic [3:0] d);
        drive(1'b1, d, 2'b01, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic key_enter();
        drive(1'b1, 4'h0, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_disp_numb"}, 64'(bus.disp_numb), 64'h0);
        check({tag, "_disp_mask"}, 64'(bus.disp_mask), 64'hFF);
        check({tag, "_disp_error"}, 64'(bus.disp_error), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_calc_start"}, 64'(bus.calc_start), 64'd0);
        check({tag, "_calc_abort"}, 64'(bus.calc_abort), 64'd0);
        check({tag, "_calc_operand"}, 64'(bus.calc_operand), 64'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    bit          r_kv, r_clr, r_cr, r_cerr;
    logic [3:0]  r_code;
    logic [1:0]  r_flags;

    initial begin
        reset = 1'b1;
        bus.key_valid = 1'b0; bus.key_code = 4'h0; bus.key_flags = 2'b00; bus.clear = 1'b0;
        bus.calc_ready = 1'b0; bus.calc_error = 1'b0; bus.calc_result = 16'h0;
        model_reset();
        mon_last = RST_SNAP;
        #2 reset = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;

        // Digits 1,2,A then Enter.
        key_enter();
        key_digit(4'h1); key_digit(4'h2); key_digit(4'hA); key_enter();
        idle(1);
        check("s1_disp_numb", 64'(bus.disp_numb), 64'h12A);
        check("s1_disp_mask", 64'(bus.disp_mask), 64'hF8);
        check("s1_calc_start", 64'(bus.calc_start), 64'd1);
        check("s1_calc_operand", 64'(bus.calc_operand), 64'h012A);
        check("s1_busy", 64'(bus.busy), 64'd1);

        // Result 0xBEEF, then chain it with Enter.
        drive(1'b1, 4'h3, 2'b01, 1'b0, 1'b1, 1'b0, 16'hBEEF);
        idle(1);
        check("s2_disp_numb", 64'(bus.disp_numb), 64'h0000BEEF);
        check("s2_disp_mask", 64'(bus.disp_mask), 64'hF0);
        key_enter();
        idle(1);
        check("s2_chain_operand", 64'(bus.calc_operand), 64'hBEEF);
        drive(1'b0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b1, 16'h0);
        idle(1);
        check("s2_error_flag", 64'(bus.disp_error), 64'd1);
        key_enter();

        // Nine digits overflow the eight-digit display.
        drive(1'b0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int d = 1; d <= 9; d++) key_digit(4'(d));
        idle(1);
        check("s3_disp_numb", 64'(bus.disp_numb), 64'h23456789);
        check("s3_disp_mask", 64'(bus.disp_mask), 64'h00);
        key_digit(4'hF);
        idle(1);
        check("s3_saturated_shift", 64'(bus.disp_numb), 64'h3456789F);

        // Timeout with no result, then a result coincident with the timeout.
        key_enter();
        idle(17);
        check("s4_calc_abort", 64'(bus.calc_abort), 64'd1);
        check("s4_disp_error", 64'(bus.disp_error), 64'd1);
        key_digit(4'h5); key_enter();
        idle(15);
        drive(1'b0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h5555);
        idle(1);
        check("s4_coincident_abort", 64'(bus.calc_abort), 64'd0);
        check("s4_coincident_numb", 64'(bus.disp_numb), 64'h5555);

        // Clear together with a digit while waiting.
        key_enter();
        idle(2);
        drive(1'b1, 4'h7, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0);
        idle(1);
        check("s5_calc_abort", 64'(bus.calc_abort), 64'd1);
        check("s5_disp_mask", 64'(bus.disp_mask), 64'hFF);
        check("s5_disp_numb", 64'(bus.disp_numb), 64'h0);

        // Asynchronous reset in the middle of a calculation.
        key_digit(4'hC); key_digit(4'h3); key_enter();
        idle(3);
        @(negedge clk);
        #2 reset = 1'b0;
        mon_en = 1'b0;
        #1 check_reset_outputs("mid");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_reset_no_abort", 64'(bus.calc_abort), 64'd0);
        end
        reset = 1'b1;
        model_reset();
        mon_last = RST_SNAP;
        mon_en = 1'b1;
        key_enter();
        key_digit(4'h9);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            r_kv    = ($urandom_range(99) < 40);
            r_code  = 4'($urandom);
            r_flags = 2'($urandom);
            r_clr   = ($urandom_range(99) < 2);
            r_cr    = (m_mode == "wait") ? ($urandom_range(99) < 8) : ($urandom_range(99) < 2);
            r_cerr  = ($urandom_range(99) < 25);
            drive(r_kv, r_code, r_flags, r_clr, r_cr, r_cerr, 16'($urandom));
        end
        idle(TIMEOUT + 4);
        check("pulse_queue_drained", 64'(pulse_q.size()), 64'd0);
        check("display_queue_drained", 64'(snap_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/entry_controller.md
ENTRY_CONTROLLER -- requirements
Module: entry_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000000, meaning the number of clk cycles to wait for calc_ready before aborting; legal range 2..2^20-1.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port key_valid  input  1  one-cycle pulse: key event present.
REQ-005 SHALL have port key_code  input  4  hex digit value of the key event.
REQ-006 SHALL have port key_flags  input  2  bit0 = digit key, bit1 = Enter key.
REQ-007 SHALL have port clear  input  1  one-cycle synchronous clear request.
REQ-008 SHALL have port calc_ready  input  1  one-cycle pulse: calculator result valid.
REQ-009 SHALL have port calc_error  input  1  calculator error, sampled only with calc_ready.
REQ-010 SHALL have port calc_result  input  16  calculator result, sampled only with calc_ready.
REQ-011 SHALL have port calc_start  output  1  one-cycle pulse: calc_operand valid, start calculation.
REQ-012 SHALL have port calc_abort  output  1  one-cycle pulse: abandon the pending calculation.
REQ-013 SHALL have port calc_operand  output  16  operand handed to the calculator.
REQ-014 SHALL have port disp_numb  output  32  eight hex digits for the display; digit 0 = bits [3:0].
REQ-015 SHALL have port disp_mask  output  8  per-digit blanking; bit i = 1 blanks digit i.
REQ-016 SHALL have port disp_error  output  1  display the error pattern.
REQ-017 SHALL have port busy  output  1  high while in WAIT_CALC.

Function
REQ-018 SHALL decode key events as follows:
- Enter: key_valid=1 and key_flags[1]=1, including key_flags=2'b11.
- Digit: key_valid=1 and key_flags=2'b01.
- Anything else: ignored.
REQ-019 SHALL implement states IDLE, ENTRY, WAIT_CALC, SHOW_RES and SHOW_ERR; all outputs SHALL be registered.
REQ-020 On a digit in IDLE or ENTRY, SHALL do all of the following and go to ENTRY:
- shift disp_numb <= {disp_numb[27:0], key_code};
- increment the 4-bit digit count, saturating at 8; at count 8, further digits still shift and the oldest digit is lost;
- set disp_mask bit i = 0 for i < count.
The new value SHALL be visible in the cycle after the key.
REQ-021 SHALL ignore Enter in IDLE.
REQ-022 On Enter in ENTRY, SHALL do all of the following, with calc_start and calc_operand valid in the cycle after the Enter:
- calc_operand <= disp_numb[15:0];
- pulse calc_start for exactly one cycle;
- clear the timeout counter;
- go to WAIT_CALC.
REQ-023 In WAIT_CALC, SHALL ignore all key events and hold busy=1.
REQ-024 In WAIT_CALC, on calc_ready with calc_error=0, SHALL do all of the following:
- disp_numb <= {16'h0000, calc_result};
- disp_mask <= 8'hF0;
- disp_error <= 0;
- go to SHOW_RES.
REQ-025 In WAIT_CALC, on calc_ready with calc_error=1, SHALL do all of the following:
- disp_error <= 1;
- disp_mask <= 8'hFF;
- go to SHOW_ERR.
REQ-026 In WAIT_CALC, if the counter reaches TIMEOUT-1 with no calc_ready, SHALL do all of the following:
- pulse calc_abort for one cycle;
- disp_error <= 1;
- disp_mask <= 8'hFF;
- go to SHOW_ERR.
REQ-027 When calc_ready and timeout occur in the same cycle, calc_ready SHALL win and calc_abort SHALL stay 0.
REQ-028 On a digit in SHOW_RES or SHOW_ERR, SHALL do all of the following and go to ENTRY:
- disp_numb <= {28'h0, key_code};
- count <= 1;
- disp_mask <= 8'hFE;
- disp_error <= 0.
REQ-029 On Enter in SHOW_RES, SHALL set calc_operand <= disp_numb[15:0] (result chaining), pulse calc_start, and go to WAIT_CALC.
REQ-030 SHALL ignore Enter in SHOW_ERR.
REQ-031 On clear in any state, SHALL set disp_numb=0, disp_mask=8'hFF, disp_error=0 and count=0, and go to IDLE.
REQ-032 If clear arrives in WAIT_CALC, SHALL also pulse calc_abort for one cycle.
REQ-033 Clear SHALL take priority over a simultaneous key event, calc_ready or timeout.
REQ-034 SHALL ignore calc_ready outside WAIT_CALC.
REQ-035 calc_start and calc_abort SHALL never be high in the same cycle.

Reset
REQ-036 While reset=0, SHALL immediately force:
- state = IDLE, count = 0;
- disp_numb = 0, disp_mask = 8'hFF;
- disp_error = 0, busy = 0;
- calc_start = 0, calc_abort = 0;
- calc_operand = 0;
- timeout counter = 0.
REQ-037 Reset asserted mid-operation, including in WAIT_CALC, SHALL abandon the operation with no calc_abort pulse.
REQ-038 After release, the first rising clk edge SHALL process inputs normally.

Verification
REQ-039 The bench SHALL cover the following scenarios:
- Digits 1, 2, A, then Enter -> disp_numb = 0x12A, disp_mask = 8'hF8; one calc_start with calc_operand = 0x012A; busy = 1.
- In WAIT_CALC, calc_ready with calc_result = 0xBEEF and calc_error = 0 -> disp_numb = 0x0000BEEF, disp_mask = 8'hF0; then Enter -> calc_start with calc_operand = 0xBEEF.
- Nine digits 1..9 -> disp_numb = 0x23456789, disp_mask = 8'h00, count stays 8.
- TIMEOUT = 16, Enter with no calc_ready -> calc_abort exactly 16 cycles after calc_start, disp_error = 1; calc_ready coincident with the timeout -> result shown, no abort.
- clear in the same cycle as a digit during WAIT_CALC -> IDLE, calc_abort pulse, disp_mask = 8'hFF, digit discarded.
- reset = 0 asserted mid-WAIT_CALC -> all outputs at reset values without waiting for a clock edge; no calc_abort.
